ghost_move_scheduler: RTL and testbench
=======================================

Name: ghost_move_scheduler

Overview:
- Frame-rate sequencer for all ghost movers.
- Each movement frame, it visits every ghost in fixed order 0..NUM_GHOSTS-1 and computes the ghost's target tile from its current position and direction.
- Target-tile wall checks share one external wall-lookup port, one ghost at a time.
- Each ghost gets a one-cycle move_en pulse if its target tile is open, or a blocked flag if not. Ghost movers step only on move_en, instead of free-running every clk.

Parameters:
- NUM_GHOSTS, 4, number of ghost movers served.
- TICK_DIV, 2500000, clk cycles per movement frame; must exceed 3*NUM_GHOSTS+2.
- TILE, 20, tile size in pixels.
- COLS, 32, tilemap columns.
- ROWS, 24, tilemap rows.
- XW, 10, x coordinate width.
- YW, 9, y coordinate width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  frame generation enable.
- ghost_x  in  NUM_GHOSTS*XW  packed x positions, ghost i at [i*XW +: XW].
- ghost_y  in  NUM_GHOSTS*YW  packed y positions.
- ghost_dir  in  NUM_GHOSTS*2  packed directions, encoded with the codebase `dir_up/`dir_down/`dir_left/`dir_right macros.
- ghost_freeze  in  NUM_GHOSTS  per-ghost skip this frame.
- ghost_fright  in  NUM_GHOSTS  per-ghost frightened flag; used only with the optional feature.
- wall_req  out  1  lookup strobe.
- wall_addr  out  $clog2(ROWS*COLS)  tile index row*COLS+col.
- wall_hit  in  1  wall bit, valid the cycle after wall_req.
- move_en  out  NUM_GHOSTS  one-cycle step grants.
- blocked  out  NUM_GHOSTS  target tile walled or off-map this frame.
- frame_done  out  1  one-cycle end-of-frame pulse.
- busy  out  1  FSM not IDLE.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, tick counter 0, FSM in IDLE, ghost index 0, frame parity 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable=1. The tick is the cycle the counter is at TICK_DIV-1; the counter then wraps to 0.
  - enable=0 clears the counter and suppresses ticks. A frame already in progress still completes.
- Tick while IDLE: blocked cleared to 0, index=0, go to SETUP. busy=1 from the next cycle.
- Tick while busy: tick dropped, overrun set. overrun clears only on reset.
- Target tile for ghost idx: col=x/TILE, row=y/TILE (floor). Then:
  - up: row-1.
  - down: row+1.
  - left: col-1.
  - right: col+1.
- SETUP state:
  - If ghost_freeze[idx]: no lookup, no grant, go to NEXT.
  - Else if target is off-map (row 0 moving up, row ROWS-1 moving down, col 0 moving left, col COLS-1 moving right): blocked[idx]<=1, no wall_req, go to NEXT.
  - Else: wall_req=1 with wall_addr=target index for exactly this one cycle, go to WAIT.
- WAIT state: sample wall_hit.
  - 0: move_en[idx] is high during the following NEXT cycle only.
  - 1: blocked[idx]<=1.
  - Go to NEXT.
- NEXT state:
  - If idx==NUM_GHOSTS-1: frame_done=1 for this cycle, parity toggles, go to IDLE.
  - Else: idx+1, go to SETUP.
- wall_addr holds its last value outside SETUP. wall_req is 0 outside SETUP.
- Inputs for ghost idx are sampled in SETUP only; changes at other times do not affect that ghost's decision.
- At most one move_en bit is high in any cycle. blocked holds from its set point until the next frame start.
- Per-ghost cost: 3 cycles with a lookup, 2 cycles when skipped.
- Reset mid-frame: all outputs 0 at once, no further grants, partial frame abandoned.

Optional Feature:
- FRIGHT_HALF_SPEED_EN defined: a ghost with ghost_fright[idx]=1 in SETUP is treated as frozen on odd-parity frames, i.e. it moves every other frame. Frame parity starts at 0 (even) after reset.
- Macro undefined: ghost_fright is ignored and parity logic is omitted.

Test Plan:
- Bench parameters: TICK_DIV=16, NUM_GHOSTS=4, walls all 0; all ghosts at (20,320) moving right.
  - -> tick at cycle 15; wall_req with wall_addr=16*32+2=514 four times.
  - -> move_en pulses 0,1,2,3 in successive NEXT cycles, 3 cycles apart.
  - -> frame_done once; blocked=0000.
- Ghost 2 at (0,100) moving left -> no wall_req for ghost 2; blocked=0100; other ghosts granted normally.
- Wall bit at index 514 set, ghost 1 at (20,320) moving right -> wall_hit=1, blocked[1]=1, no move_en[1].
- ghost_freeze=1001 -> only two wall_req this frame; frame length 2+3+3+2 cycles; move_en only for ghosts 1 and 2.
- TICK_DIV=8 with NUM_GHOSTS=4 (illegal setting) -> second tick arrives while busy; overrun=1 and stays 1.
- FRIGHT_HALF_SPEED_EN, ghost_fright=0001, open map -> ghost 0 granted on frames 0, 2, 4 only. Reset asserted mid-frame -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/ghost_move_scheduler.sv
// ghost_move_scheduler
//   Frame-rate sequencer for the ghost movers. Once per movement frame it
//   walks the ghosts in order 0..NUM_GHOSTS-1, works out each ghost's target
//   tile from its position and direction, checks that tile through the
//   shared wall-lookup port and grants a one-cycle move_en pulse when the
//   tile is open (or raises blocked when it is walled or off the map).
//
// Optional feature (compile-time macro FRIGHT_HALF_SPEED_EN):
//   When defined, a frightened ghost is skipped on odd-parity frames so it
//   moves at half speed. When undefined, ghost_fright is ignored and no
//   frame-parity state exists.
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   enable         frame generation enable (clears the tick counter when 0)
//   ghost_x/y/dir  packed per-ghost position and direction, ghost i at [i*W +: W]
//   ghost_freeze   per-ghost skip for this frame
//   ghost_fright   per-ghost frightened flag (optional feature only)
//   wall_req       one-cycle lookup strobe, wall_addr = row*COLS+col
//   wall_hit       wall bit, valid the cycle after wall_req
//   move_en        one-cycle step grants, at most one bit high
//   blocked        target walled or off-map this frame
//   frame_done     one-cycle end-of-frame pulse
//   busy           sequencer not idle
//   overrun        sticky: a tick arrived while a frame was still running

`ifndef DIR_UP
`define DIR_UP    2'd0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN  2'd1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT  2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module ghost_move_scheduler #(
    parameter int NUM_GHOSTS = 4,
    parameter int TICK_DIV   = 2500000,
    parameter int TILE       = 20,
    parameter int COLS       = 32,
    parameter int ROWS       = 24,
    parameter int XW         = 10,
    parameter int YW         = 9,
    localparam int AW        = $clog2(ROWS*COLS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_GHOSTS*XW-1:0] ghost_x,
    input  logic [NUM_GHOSTS*YW-1:0] ghost_y,
    input  logic [NUM_GHOSTS*2-1:0]  ghost_dir,
    input  logic [NUM_GHOSTS-1:0]    ghost_freeze,
    input  logic [NUM_GHOSTS-1:0]    ghost_fright,
    output logic                     wall_req,
    output logic [AW-1:0]            wall_addr,
    input  logic                     wall_hit,
    output logic [NUM_GHOSTS-1:0]    move_en,
    output logic [NUM_GHOSTS-1:0]    blocked,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     overrun
);

    localparam int IW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, NEXT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic [IW-1:0]   idx;
    logic            last_ghost;
    logic            grant_q;     // lookup came back open; grant in NEXT
    logic [AW-1:0]   addr_q;      // last issued lookup address

    logic [XW-1:0]   gx, col, tcol;
    logic [YW-1:0]   gy, row, trow;
    logic [1:0]      gd;
    logic            gfreeze;
    logic            off_map, skip, lookup;
    logic [AW-1:0]   tgt_addr;

    // ------------------------------------------------------------------
    // Frame tick divider
    // ------------------------------------------------------------------
    assign tick = enable && (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (!enable || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    // ------------------------------------------------------------------
    // Current-ghost selection and target tile
    // ------------------------------------------------------------------
`ifdef FRIGHT_HALF_SPEED_EN
    logic gfright;
    logic parity;
`else
    logic unused_fright;
    assign unused_fright = ^ghost_fright;
`endif

    always_comb begin
        gx      = '0;
        gy      = '0;
        gd      = '0;
        gfreeze = 1'b0;
`ifdef FRIGHT_HALF_SPEED_EN
        gfright = 1'b0;
`endif
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            if (idx == IW'(i)) begin
                gx      = ghost_x[i*XW +: XW];
                gy      = ghost_y[i*YW +: YW];
                gd      = ghost_dir[i*2 +: 2];
                gfreeze = ghost_freeze[i];
`ifdef FRIGHT_HALF_SPEED_EN
                gfright = ghost_fright[i];
`endif
            end
        end
    end

    always_comb begin
        col     = gx / XW'(TILE);
        row     = gy / YW'(TILE);
        tcol    = col;
        trow    = row;
        // A ghost already outside the map can never have a valid target.
        off_map = (col >= XW'(COLS)) || (row >= YW'(ROWS));
        case (gd)
            `DIR_UP: begin
                trow = row - YW'(1);
                if (row == '0) off_map = 1'b1;
            end
            `DIR_DOWN: begin
                trow = row + YW'(1);
                if (row >= YW'(ROWS - 1)) off_map = 1'b1;
            end
            `DIR_LEFT: begin
                tcol = col - XW'(1);
                if (col == '0) off_map = 1'b1;
            end
            default: begin
                tcol = col + XW'(1);
                if (col >= XW'(COLS - 1)) off_map = 1'b1;
            end
        endcase
    end

    assign tgt_addr = AW'(trow) * AW'(COLS) + AW'(tcol);

`ifdef FRIGHT_HALF_SPEED_EN
    assign skip = gfreeze || (gfright && parity);
`else
    assign skip = gfreeze;
`endif
    assign lookup     = !skip && !off_map;
    assign last_ghost = (idx == IW'(NUM_GHOSTS - 1));

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = SETUP;
            SETUP:   state_nxt = lookup ? WAIT : NEXT;
            WAIT:    state_nxt = NEXT;
            NEXT:    state_nxt = last_ghost ? IDLE : SETUP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wall_req   = 1'b0;
        wall_addr  = addr_q;
        move_en    = '0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            SETUP: begin
                if (lookup) begin
                    wall_req  = 1'b1;
                    wall_addr = tgt_addr;
                end
            end
            NEXT: begin
                if (grant_q) move_en[idx] = 1'b1;
                frame_done = last_ghost;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer datapath: index, grant, blocked, address hold, overrun
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            grant_q <= 1'b0;
            addr_q  <= '0;
            blocked <= '0;
            overrun <= 1'b0;
`ifdef FRIGHT_HALF_SPEED_EN
            parity  <= 1'b0;
`endif
        end else begin
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        blocked <= '0;
                        idx     <= '0;
                    end
                end
                SETUP: begin
                    grant_q <= 1'b0;
                    if (!skip && off_map) blocked[idx] <= 1'b1;
                    if (lookup) addr_q <= tgt_addr;
                end
                WAIT: begin
                    grant_q <= !wall_hit;
                    if (wall_hit) blocked[idx] <= 1'b1;
                end
                NEXT: begin
                    if (last_ghost) begin
`ifdef FRIGHT_HALF_SPEED_EN
                        parity <= !parity;
`endif
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_move_scheduler.sv
`ifndef DIR_UP
`define DIR_UP    2'd0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN  2'd1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT  2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module tb_ghost_move_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [39:0] ghost_x;
    logic [35:0] ghost_y;
    logic [7:0]  ghost_dir;
    logic [3:0]  ghost_freeze;
    logic [3:0]  ghost_fright;
    logic        wall_req;
    logic [9:0]  wall_addr;
    logic        wall_hit;
    logic [3:0]  move_en;
    logic [3:0]  blocked;
    logic        frame_done;
    logic        busy;
    logic        overrun;

    // Second instance with an illegally short frame period.
    logic        wall_req_ov;
    logic [9:0]  wall_addr_ov;
    logic        wall_hit_ov;
    logic [3:0]  move_en_ov;
    logic [3:0]  blocked_ov;
    logic        frame_done_ov;
    logic        busy_ov;
    logic        overrun_ov;

    logic        walls [0:767];

    int errors = 0;
    int checks = 0;
    int cyc;
    int n_req, n_514, last_addr, multi_mv, n_done, got, f_start, f_end, mv_total;
    int mv_cnt [4];
    int mv_cyc [4];
    logic [3:0] mv_mask;
    logic [3:0] blk_at_done;
    logic [4:0] fr_got;
    int bad;

    always #5 clk = ~clk;

    assign wall_hit_ov = 1'b0;

    always @(posedge clk) wall_hit <= wall_req ? walls[wall_addr] : 1'b0;

    ghost_move_scheduler #(.NUM_GHOSTS(4), .TICK_DIV(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_dir(ghost_dir),
        .ghost_freeze(ghost_freeze), .ghost_fright(ghost_fright),
        .wall_req(wall_req), .wall_addr(wall_addr), .wall_hit(wall_hit),
        .move_en(move_en), .blocked(blocked), .frame_done(frame_done),
        .busy(busy), .overrun(overrun)
    );

    ghost_move_scheduler #(.NUM_GHOSTS(4), .TICK_DIV(8)) dut_ov (
        .clk(clk), .reset(reset), .enable(enable),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_dir(ghost_dir),
        .ghost_freeze(ghost_freeze), .ghost_fright(ghost_fright),
        .wall_req(wall_req_ov), .wall_addr(wall_addr_ov), .wall_hit(wall_hit_ov),
        .move_en(move_en_ov), .blocked(blocked_ov), .frame_done(frame_done_ov),
        .busy(busy_ov), .overrun(overrun_ov)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ghost(input int i, input int x, input int y, input logic [1:0] d);
        ghost_x[i*10 +: 10] = 10'(x);
        ghost_y[i*9 +: 9]   = 9'(y);
        ghost_dir[i*2 +: 2] = d;
    endtask

    // Observe one whole frame on falling edges until frame_done (bounded).
    task automatic run_frame();
        n_req = 0; n_514 = 0; last_addr = -1; multi_mv = 0; n_done = 0;
        got = 0; f_start = -1; f_end = -1;
        for (int i = 0; i < 4; i++) begin
            mv_cnt[i] = 0;
            mv_cyc[i] = -1;
        end
        for (int k = 0; k < 60 && got == 0; k++) begin
            @(negedge clk);
            cyc++;
            if (busy && f_start < 0) f_start = cyc;
            if (wall_req) begin
                n_req++;
                last_addr = int'(wall_addr);
                if (wall_addr == 10'd514) n_514++;
            end
            if ($countones(move_en) > 1) multi_mv++;
            for (int i = 0; i < 4; i++) begin
                if (move_en[i]) begin
                    mv_cnt[i]++;
                    if (mv_cyc[i] < 0) mv_cyc[i] = cyc;
                end
            end
            if (frame_done) begin
                n_done++;
                f_end = cyc;
                got = 1;
                blk_at_done = blocked;
            end
        end
        mv_total = 0;
        for (int i = 0; i < 4; i++) begin
            mv_mask[i] = (mv_cnt[i] != 0);
            mv_total += mv_cnt[i];
        end
        chk("frame_done_seen", got, 1);
        chk("single_grant", multi_mv, 0);
    endtask

    initial begin
        for (int i = 0; i < 768; i++) walls[i] = 1'b0;
        reset = 1'b1;
        enable = 1'b1;
        ghost_freeze = 4'b0000;
        ghost_fright = 4'b0000;
        for (int i = 0; i < 4; i++) set_ghost(i, 20, 320, `DIR_RIGHT);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_move_en", move_en, 0);
        chk("rst_blocked", blocked, 0);
        chk("rst_wall_req", wall_req, 0);
        chk("rst_wall_addr", wall_addr, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);

        reset = 1'b0;
        cyc = 0;

        // Frame 1: open map, all at (20,320) moving right -> target 514
        run_frame();
        chk("f1_start", f_start, 16);
        chk("f1_req", n_req, 4);
        chk("f1_addr514", n_514, 4);
        chk("f1_mv0", mv_cyc[0], 18);
        chk("f1_mv1", mv_cyc[1], 21);
        chk("f1_mv2", mv_cyc[2], 24);
        chk("f1_mv3", mv_cyc[3], 27);
        chk("f1_mv_total", mv_total, 4);
        chk("f1_end", f_end, 27);
        chk("f1_blocked", blk_at_done, 4'b0000);
        @(negedge clk); cyc++;
        chk("f1_idle_after", busy, 0);
        chk("f1_done_once", frame_done, 0);

        // Frame 2: ghost 2 at (0,100) moving left -> off-map
        set_ghost(2, 0, 100, `DIR_LEFT);
        run_frame();
        chk("f2_req", n_req, 3);
        chk("f2_blocked", blk_at_done, 4'b0100);
        chk("f2_mask", mv_mask, 4'b1011);
        chk("f2_len", f_end - f_start + 1, 11);
        chk("ov_overrun_a", overrun_ov, 1);

        // Frame 3: wall at 514, ghost 1 heads into it; others target 166
        walls[514] = 1'b1;
        set_ghost(0, 100, 100, `DIR_RIGHT);
        set_ghost(1, 20, 320, `DIR_RIGHT);
        set_ghost(2, 100, 100, `DIR_RIGHT);
        set_ghost(3, 100, 100, `DIR_RIGHT);
        run_frame();
        chk("f3_req", n_req, 4);
        chk("f3_addr514", n_514, 1);
        chk("f3_blocked", blk_at_done, 4'b0010);
        chk("f3_mask", mv_mask, 4'b1101);
        chk("f3_mv_total", mv_total, 3);

        // Frame 4: freeze ghosts 0 and 3, open map
        walls[514] = 1'b0;
        for (int i = 0; i < 4; i++) set_ghost(i, 20, 320, `DIR_RIGHT);
        ghost_freeze = 4'b1001;
        run_frame();
        chk("f4_req", n_req, 2);
        chk("f4_len", f_end - f_start + 1, 10);
        chk("f4_mask", mv_mask, 4'b0110);
        chk("f4_blocked", blk_at_done, 4'b0000);

        // Frame 5: map edges (up at row 0, down at row 23, right at col 31)
        ghost_freeze = 4'b0000;
        set_ghost(0, 20, 0, `DIR_UP);
        set_ghost(1, 20, 460, `DIR_DOWN);
        set_ghost(2, 620, 100, `DIR_RIGHT);
        set_ghost(3, 20, 20, `DIR_UP);
        run_frame();
        chk("f5_req", n_req, 1);
        chk("f5_addr", last_addr, 1);
        chk("f5_blocked", blk_at_done, 4'b0111);
        chk("f5_mask", mv_mask, 4'b1000);
        @(negedge clk); cyc++;
        chk("f5_addr_hold", wall_addr, 1);
        chk("main_no_overrun", overrun, 0);
        chk("ov_overrun_b", overrun_ov, 1);

        // Fresh reset, frightened ghost 0 over five frames
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) set_ghost(i, 20, 320, `DIR_RIGHT);
        ghost_fright = 4'b0001;
        for (int f = 0; f < 5; f++) begin
            run_frame();
            fr_got[f] = mv_mask[0];
        end
`ifdef FRIGHT_HALF_SPEED_EN
        chk("fright_g0_frames", fr_got, 5'b10101);
`else
        chk("fright_g0_frames", fr_got, 5'b11111);
`endif

        // Reset in the middle of a frame, during a grant cycle
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            @(negedge clk);
            if (move_en != 4'b0000) got = 1;
        end
        chk("midframe_grant_seen", got, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_move_en", move_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_blocked", blocked, 0);
        chk("mid_rst_wall_req", wall_req, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_overrun_ov", overrun_ov, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (move_en != 4'b0000 || busy) bad++;
        end
        chk("post_rst_quiet", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
